dff_pipeline: RTL and testbench
===============================

Name: dff_pipeline

Overview:
- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, DEPTH-stage registered delay line.
- Adds a per-stage valid bit, a clock enable (stall), a flush, a registered occupancy count and a tap bus exposing every stage.
- Used in the Morse decoder datapath to align sampled key/timing signals with downstream decode logic, and as a generic multi-cycle delay elsewhere.

Parameters:
WIDTH, 1, data width of each stage in bits (>=1)
DEPTH, 4, number of register stages, i.e. latency in enabled cycles (>=1)
RESET_VALUE, 0, value loaded into every data stage on reset (WIDTH bits, zero-extended/truncated)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
en  input  1  stage advance enable; 0 = hold all state
flush  input  1  clear all valid bits (data registers untouched except by normal shifting)
D  input  WIDTH  data into stage 0
d_valid  input  1  qualifier for D
Q  output  WIDTH  data of last stage (stage DEPTH-1)
q_valid  output  1  valid bit of last stage
taps  output  WIDTH*DEPTH  all stage data; stage i at bits [i*WIDTH +: WIDTH], stage 0 least significant
occupancy  output  $clog2(DEPTH+1)  count of stages whose valid bit is set

Behaviour:
- All state updates on rising edge of clk. Outputs are direct register outputs; no combinational path from any input to any output.
- Reset (rst=1 at an edge, regardless of en/flush):
  - every data stage = RESET_VALUE; every valid bit = 0; occupancy = 0.
  - Q = RESET_VALUE, q_valid = 0, taps = {DEPTH{RESET_VALUE}}.
  - Reset mid-stream discards all in-flight entries; the next cycle behaves as after power-up reset.
- Priority at each edge: rst > flush > en.
- en=1, flush=0:
  - stage0 <= D, valid0 <= d_valid.
  - stage i <= stage i-1, valid i <= valid i-1 for i = 1..DEPTH-1.
  - Entry leaving stage DEPTH-1 is dropped; no backpressure, no overflow condition.
- en=0, flush=0: all data, valid and occupancy hold. D/d_valid ignored.
- flush=1 (rst=0):
  - All valid bits <= 0 and occupancy <= 0, including the incoming d_valid.
  - Data registers shift if en=1 and hold if en=0; data is don't-care to consumers when valid=0, but the defined behaviour above is required and checked.
- Latency: a word presented with en=1 at edge k appears on Q after edge k+DEPTH-1, i.e. visible in the cycle following the DEPTH-th enabled edge. Stalled (en=0) cycles add latency one-for-one.
- occupancy: registered popcount of the next-state valid vector, updated at the same edge as the valid bits. It is never stale and always equals the number of set valid bits. Range 0..DEPTH; width holds DEPTH exactly (DEPTH=4 -> 3 bits, max 4).
- Occupancy update for en=1, flush=0 at each edge:
  - If d_valid=1 and the last stage is invalid: occupancy +1.
  - If d_valid=0 and the last stage is valid: occupancy -1.
  - Otherwise: unchanged.
  - An implementation may compute this by popcount or by up/down counter, but the result must be identical.
- Degenerate case DEPTH=1: Q is a WIDTH-bit D flip-flop with enable; taps == Q; occupancy is 1 bit, equal to q_valid.
- X/undefined inputs while en=0 and rst=0 must not disturb state.

Test Plan:
- Reset: WIDTH=8, DEPTH=4, RESET_VALUE=8'hA5, drive D=8'hFF, d_valid=1, en=1 with rst=1 for 3 cycles -> Q=8'hA5, q_valid=0, taps=32'hA5A5A5A5, occupancy=0 throughout.
- Latency/fill: after reset, en=1, d_valid=1, D=1,2,3,4,5 on successive edges -> occupancy 1,2,3,4,4; Q=1 with q_valid=1 in the cycle after the 4th edge, then Q=2 after the 5th; taps after 4th edge = {1,2,3,4} (stage3..stage0).
- Stall: fill with 1..4, then en=0 for 5 cycles while D toggles -> Q=1, taps and occupancy=4 unchanged. Re-assert en -> Q advances to 2 on the first enabled edge.
- Bubbles: en=1, d_valid pattern 1,0,1,0 with D=10,11,12,13 -> q_valid sequence 1,0,1,0 starting after the 4th edge, Q=10 then 12 on valid cycles; occupancy settles at 2.
- Flush: fill to occupancy=4, assert flush=1 with en=1, d_valid=1, D=9 for one edge -> occupancy=0, q_valid=0, stage0 data=9 (taps shifted). Then 4 more enabled valid edges -> occupancy=4. Repeat with en=0 -> data unchanged, valids cleared.
- Reset mid-operation and DEPTH=1: assert rst at occupancy=3 together with flush=1 and en=1 -> all stages RESET_VALUE, occupancy=0. Instance with DEPTH=1, WIDTH=1: Q follows D one enabled edge later, occupancy==q_valid every cycle.

Source files
------------

// File: rtl/dff_pipeline.sv
// WIDTH-bit, DEPTH-stage registered delay line with per-stage valid bits.
// It also provides stall (en), flush, a registered occupancy count and a tap bus.
module dff_pipeline #(
  parameter int               WIDTH       = 1,
  parameter int               DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             D,
  input  logic                         d_valid,
  output logic [WIDTH-1:0]             Q,
  output logic                         q_valid,
  output logic [WIDTH*DEPTH-1:0]       taps,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int OW = $clog2(DEPTH+1);

  logic [WIDTH*DEPTH-1:0] r_data;
  logic [DEPTH-1:0]       r_valid;
  logic [OW-1:0]          r_occ;

  logic [WIDTH*DEPTH-1:0] w_data_shift;
  logic [DEPTH-1:0]       w_valid_shift;
  logic [DEPTH-1:0]       w_valid_nxt;

  // Stage 0 sits in the least significant slot, so a shift moves every stage up by one.
  generate
    if (DEPTH == 1) begin : g_single
      assign w_data_shift  = D;
      assign w_valid_shift = d_valid;
    end else begin : g_multi
      assign w_data_shift  = {r_data[(DEPTH-1)*WIDTH-1:0], D};
      assign w_valid_shift = {r_valid[DEPTH-2:0], d_valid};
    end
  endgenerate

  always_comb begin
    w_valid_nxt = r_valid;
    if (flush)   w_valid_nxt = '0;
    else if (en) w_valid_nxt = w_valid_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= {DEPTH{RESET_VALUE}};
      r_valid <= '0;
      r_occ   <= '0;
    end else begin
      if (en) r_data <= w_data_shift;
      r_valid <= w_valid_nxt;
      // The count is taken from the next-state vector, so it never lags the valid bits.
      r_occ   <= OW'($countones(w_valid_nxt));
    end
  end

  assign Q         = r_data[(DEPTH-1)*WIDTH +: WIDTH];
  assign q_valid   = r_valid[DEPTH-1];
  assign taps      = r_data;
  assign occupancy = r_occ;

endmodule

// File: tb/tb_dff_pipeline.sv
// Scoreboard bench for dff_pipeline: an 8x4 instance with RESET_VALUE A5 and a 1x1 instance.
// The stimulus pushes expected words into queues, and a monitor pops them whenever Q advances with valid set.
module tb_dff_pipeline;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, flush = 1'b0, d_valid = 1'b0;
  logic [7:0]  D = '0;
  logic [7:0]  Q;
  logic        q_valid;
  logic [31:0] taps;
  logic [2:0]  occupancy;

  logic        en1 = 1'b0, fl1 = 1'b0, d1 = 1'b0, dv1 = 1'b0;
  logic        Q1, qv1, taps1, occ1;

  int checks = 0;
  int errors = 0;

  logic [7:0] sbq[$];
  logic       sb1[$];
  logic       last_en = 1'b0, last_en1 = 1'b0;

  always #5 clk = ~clk;

  dff_pipeline #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(8'hA5)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .D(D), .d_valid(d_valid),
    .Q(Q), .q_valid(q_valid), .taps(taps), .occupancy(occupancy)
  );

  dff_pipeline #(.WIDTH(1), .DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .flush(fl1), .D(d1), .d_valid(dv1),
    .Q(Q1), .q_valid(qv1), .taps(taps1), .occupancy(occ1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Q advances only on enabled edges, so the monitor pops only after an edge where en was high.
  always @(posedge clk) begin
    last_en  <= en;
    last_en1 <= en1;
  end

  always @(negedge clk) begin
    if (last_en && q_valid) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got Q=%h expected no valid output", Q);
      end else begin
        logic [7:0] e;
        e = sbq.pop_front();
        if (Q !== e) begin
          errors++;
          $display("FAIL sb_Q: got %h expected %h", Q, e);
        end
      end
    end
    if (last_en1 && qv1) begin
      checks++;
      if (sb1.size() == 0) begin
        errors++;
        $display("FAIL sb1_unexpected: got Q1=%b expected no valid output", Q1);
      end else begin
        logic e1;
        e1 = sb1.pop_front();
        if (Q1 !== e1) begin
          errors++;
          $display("FAIL sb1_Q: got %b expected %b", Q1, e1);
        end
      end
    end
  end

  task automatic step(input logic r, input logic e, input logic f, input logic [7:0] d, input logic dv);
    rst = r; en = e; flush = f; D = d; d_valid = dv;
    en1 = 1'b0; fl1 = 1'b0;
    @(posedge clk);
    if (r || f) sbq.delete();
    else if (e && dv) sbq.push_back(d);
    if (r) sb1.delete();
    #1;
  endtask

  task automatic step1(input logic e, input logic f, input logic d, input logic dv);
    rst = 1'b0; en = 1'b0; flush = 1'b0;
    en1 = e; fl1 = f; d1 = d; dv1 = dv;
    @(posedge clk);
    if (f) sb1.delete();
    else if (e && dv) sb1.push_back(d);
    #1;
  endtask

  task automatic chk_main(input string n, input logic [31:0] t, input logic qv, input logic [2:0] oc);
    chk({n, "_taps"}, taps, t);
    chk({n, "_qv"}, {31'b0, q_valid}, {31'b0, qv});
    chk({n, "_occ"}, {29'b0, occupancy}, {29'b0, oc});
  endtask

  typedef struct { logic e, f, d, dv, eq, eqv; } v1_t;
  v1_t t1[7];

  initial begin
    // Reset held for three edges with live inputs.
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 8'hFF, 1);
      chk("rst_Q", {24'b0, Q}, 32'hA5);
      chk_main("rst", 32'hA5A5A5A5, 0, 0);
    end
    chk("rst1_Q", {31'b0, Q1}, 0);
    chk("rst1_occ", {31'b0, occ1}, 0);

    // Fill and latency.
    step(0, 1, 0, 8'd1, 1); chk_main("fill1", 32'hA5A5A501, 0, 1);
    step(0, 1, 0, 8'd2, 1); chk_main("fill2", 32'hA5A50102, 0, 2);
    step(0, 1, 0, 8'd3, 1); chk_main("fill3", 32'hA5010203, 0, 3);
    step(0, 1, 0, 8'd4, 1); chk_main("fill4", 32'h01020304, 1, 4);
    step(0, 1, 0, 8'd5, 1); chk_main("fill5", 32'h02030405, 1, 4);

    // Stall with toggling and undefined inputs.
    step(1, 0, 0, 8'h00, 0);
    for (int i = 1; i <= 4; i++) step(0, 1, 0, 8'(i), 1);
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) step(0, 0, 0, 8'hxx, 1'bx);
      else            step(0, 0, 0, 8'(8'h3C ^ i), 1);
      chk("stall_Q", {24'b0, Q}, 32'h01);
      chk_main("stall", 32'h01020304, 1, 4);
    end
    step(0, 1, 0, 8'd6, 1); chk_main("resume", 32'h02030406, 1, 4);

    // Bubbles.
    step(1, 0, 0, 8'h00, 0);
    step(0, 1, 0, 8'd10, 1); chk("bub1_occ", {29'b0, occupancy}, 1);
    step(0, 1, 0, 8'd11, 0); chk("bub2_occ", {29'b0, occupancy}, 1);
    step(0, 1, 0, 8'd12, 1); chk("bub3_occ", {29'b0, occupancy}, 2);
    step(0, 1, 0, 8'd13, 0); chk_main("bub4", 32'h0A0B0C0D, 1, 2);
    step(0, 1, 0, 8'd0, 0);  chk_main("bub5", 32'h0B0C0D00, 0, 1);
    step(0, 1, 0, 8'd0, 0);  chk_main("bub6", 32'h0C0D0000, 1, 1);
    step(0, 1, 0, 8'd0, 0);  chk_main("bub7", 32'h0D000000, 0, 0);

    // Flush while enabled, refill, then flush while stalled.
    step(1, 0, 0, 8'h00, 0);
    for (int i = 1; i <= 4; i++) step(0, 1, 0, 8'(i), 1);
    chk("pre_flush_occ", {29'b0, occupancy}, 4);
    step(0, 1, 1, 8'd9, 1); chk_main("flush_en", 32'h02030409, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'(20 + i), 1);
    chk_main("refill", 32'h14151617, 1, 4);
    step(0, 0, 1, 8'hFF, 1); chk_main("flush_hold", 32'h14151617, 0, 0);

    // Reset mid-stream beats flush and en.
    step(1, 0, 0, 8'h00, 0);
    for (int i = 1; i <= 3; i++) step(0, 1, 0, 8'(i), 1);
    chk_main("pre_rst", 32'hA5010203, 0, 3);
    step(1, 1, 1, 8'h77, 1); chk_main("mid_rst", 32'hA5A5A5A5, 0, 0);
    step(0, 1, 0, 8'd7, 1);  chk_main("post_rst", 32'hA5A5A507, 0, 1);

    // DEPTH=1, WIDTH=1 instance.
    t1[0] = '{1, 0, 1, 1, 1, 1};
    t1[1] = '{1, 0, 0, 1, 0, 1};
    t1[2] = '{0, 0, 1'bx, 1'bx, 0, 1};
    t1[3] = '{1, 0, 1, 0, 1, 0};
    t1[4] = '{1, 0, 1, 1, 1, 1};
    t1[5] = '{1, 1, 0, 1, 0, 0};
    t1[6] = '{1, 0, 0, 1, 0, 1};
    foreach (t1[i]) begin
      step1(t1[i].e, t1[i].f, t1[i].d, t1[i].dv);
      chk("d1_Q", {31'b0, Q1}, {31'b0, t1[i].eq});
      chk("d1_qv", {31'b0, qv1}, {31'b0, t1[i].eqv});
      chk("d1_occ", {31'b0, occ1}, {31'b0, t1[i].eqv});
      chk("d1_taps", {31'b0, taps1}, {31'b0, t1[i].eq});
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
